slave_regfile: RTL and testbench
================================

Name: slave_regfile

Overview:
Slave-side responder for the master/slave valid-ready link: it is the receiving end of valid_slaveN / addr_out / value_out / ready_slaveN.
- Accepts one 3-bit address + 3-bit value write per transaction into an 8-entry x 3-bit register file.
- Inserts programmable ready latency and a post-write busy period.
- Exposes a combinational read port and a write counter for status/debug.
- Two instances sit behind the arbiter, one per slave.

Parameters:
READY_DELAY, 2, cycles from valid_in first sampled in idle to ready_out high; legal range 1..15
BUSY_CYCLES, 1, cycles ready_out stays low after an accepted write before returning to idle; legal range 0..15
ADDR_W, 3, address width (8 entries)
VAL_W, 3, data width per entry

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  request valid from arbiter (its valid_slaveN)
addr_in  in  ADDR_W  write address, meaningful while valid_in high
value_in  in  VAL_W  write data, meaningful while valid_in high
ready_out  out  1  ready to arbiter (its ready_slaveN); registered Moore output
ack_out  out  1  one-cycle pulse in the cycle after a write is accepted
rd_addr  in  ADDR_W  read address
rd_data  out  VAL_W  combinational mem[rd_addr]
wr_count  out  8  number of accepted writes, wraps 255->0
last_addr  out  ADDR_W  address of the most recent accepted write

Behaviour:
- Reset (async, rst_n low):
  - state=S_IDLE; cnt=0.
  - ready_out=0, ack_out=0, wr_count=0, last_addr=0.
  - All mem entries=0, so rd_data=0.
- States: S_IDLE, S_WAIT, S_READY, S_BUSY. ready_out=1 only in S_READY.
- S_IDLE, valid_in=1:
  - READY_DELAY==1 -> S_READY.
  - Otherwise -> S_WAIT, cnt=READY_DELAY-2.
  - Result: ready_out rises exactly READY_DELAY edges after valid_in is first sampled.
- S_WAIT:
  - valid_in=0 -> S_IDLE (abort, no write).
  - Else cnt==0 -> S_READY; otherwise cnt decrements.
- S_READY, valid_in=1 (handshake): at that edge:
  - mem[addr_in]<=value_in; last_addr<=addr_in; wr_count<=wr_count+1; ack_out<=1.
  - Next state: S_BUSY with cnt=BUSY_CYCLES-1 if BUSY_CYCLES>0, else S_IDLE.
- S_READY, valid_in=0 -> S_IDLE, no write.
- S_BUSY:
  - ready_out=0; valid_in is ignored.
  - cnt==0 -> S_IDLE; otherwise cnt decrements.
- Back-to-back requests: with BUSY_CYCLES=0 and valid_in held high, the next acceptance is READY_DELAY+1 edges after the previous one, because S_IDLE must re-sample valid_in.
- ack_out: high for exactly one cycle per accepted write, otherwise 0.
- Read port:
  - rd_data is combinational from registered mem.
  - A write accepted at edge T is visible on rd_data after T.
  - Reading the address being written in the same cycle returns the old value.
- Illegal state encodings -> S_IDLE.
- Reset mid-transaction: immediate return to reset values. The in-flight write is lost if it has not been accepted; an already-accepted write is also cleared, because reset zeroes mem.
- addr_in/value_in are sampled only at the accept edge; changes while waiting have no effect.

Decomposition:
- Shared package slave_pkg:
  - State encoding constants S_IDLE=2'd0, S_WAIT=2'd1, S_READY=2'd2, S_BUSY=2'd3.
  - ADDR_W=3, VAL_W=3, DEPTH=8.
- One sub-module, regfile_8x3:
  - Async-reset storage.
  - Single write port (we, waddr, wdata).
  - Combinational read port.
- The FSM, counters and status registers stay in slave_regfile.

Test Plan:
- Reset, then rd_addr swept 0..7 -> rd_data=0 for all; ready_out=0, ack_out=0, wr_count=0.
- READY_DELAY=2, BUSY_CYCLES=1; valid_in=1, addr_in=5, value_in=6 from edge 0, dropped after the handshake -> ready_out high in cycle 2 only; ack_out high in cycle 3; mem[5]=6; wr_count=1; last_addr=5.
- valid_in pulsed for 1 cycle (READY_DELAY=3) -> FSM returns to S_IDLE; ready_out never rises; wr_count unchanged; mem unchanged.
- BUSY_CYCLES=0, valid_in held high with addr_in cycling 1,2,3 and values 7,4,1 -> accepts spaced READY_DELAY+1 cycles; three ack pulses; mem[1..3]=7,4,1; wr_count=3.
- rst_n asserted while in S_WAIT after prior writes -> outputs and mem return to 0 asynchronously, before the next clock edge; after release, a new write of value 2 to address 0 completes normally.
- 256 writes -> wr_count wraps to 0; mem[last_addr] equals the last value written.

Source files
------------

// File: rtl/slave_pkg.sv
// slave_pkg: shared FSM state encoding and default geometry for the slave register file
package slave_pkg;
  localparam int ADDR_W = 3;
  localparam int VAL_W = 3;
  localparam int DEPTH = 8;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2,
    S_BUSY  = 2'd3
  } state_t;
endpackage

// File: rtl/regfile_8x3.sv
// regfile_8x3: async-reset storage; ports clk, rst_n, we/waddr/wdata write port, raddr -> rdata combinational read
module regfile_8x3 import slave_pkg::*; #(
  parameter int AW = ADDR_W,
  parameter int DW = VAL_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/slave_regfile.sv
// slave_regfile: valid/ready slave writing a register file; ports clk, rst_n, valid_in/addr_in/value_in -> ready_out/ack_out, rd_addr -> rd_data, wr_count/last_addr status
module slave_regfile #(
  parameter int READY_DELAY = 2,
  parameter int BUSY_CYCLES = 1,
  parameter int ADDR_W = 3,
  parameter int VAL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [VAL_W-1:0]  value_in,
  output logic              ready_out,
  output logic              ack_out,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [VAL_W-1:0]  rd_data,
  output logic [7:0]        wr_count,
  output logic [ADDR_W-1:0] last_addr
);
  import slave_pkg::*;
  localparam logic [3:0] RD_INIT = READY_DELAY > 1 ? 4'(READY_DELAY - 2) : 4'd0;
  localparam logic [3:0] BUSY_INIT = BUSY_CYCLES > 0 ? 4'(BUSY_CYCLES - 1) : 4'd0;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic we;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      ack_out <= 1'b0;
      wr_count <= '0;
      last_addr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ack_out <= we;
      if (we) begin
        wr_count <= wr_count + 8'd1;
        last_addr <= addr_in;
      end
    end
  always_comb begin
    state_n = S_IDLE;
    cnt_n = cnt - 4'd1;
    case (state)
      S_IDLE: begin
        state_n = !valid_in ? S_IDLE : READY_DELAY == 1 ? S_READY : S_WAIT;
        cnt_n = RD_INIT;
      end
      S_WAIT: state_n = !valid_in ? S_IDLE : cnt == 4'd0 ? S_READY : S_WAIT;
      S_READY: begin
        state_n = valid_in && BUSY_CYCLES > 0 ? S_BUSY : S_IDLE;
        cnt_n = BUSY_INIT;
      end
      S_BUSY: state_n = cnt == 4'd0 ? S_IDLE : S_BUSY;
      default: state_n = S_IDLE;
    endcase
  end
  always_comb begin
    ready_out = state == S_READY;
    we = ready_out && valid_in;
  end
  regfile_8x3 #(.AW(ADDR_W), .DW(VAL_W)) u_mem (
    .clk(clk),
    .rst_n(rst_n),
    .we(we),
    .waddr(addr_in),
    .wdata(value_in),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_slave_regfile.sv
// tb_slave_regfile: scoreboard bench for two slave_regfile instances (READY_DELAY/BUSY_CYCLES 2/1 and 3/0)
module tb_slave_regfile;
  typedef struct {
    int i;
    logic [2:0] a;
    logic [2:0] v;
    logic [7:0] c;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic vi [2];
  logic [2:0] ai [2];
  logic [2:0] di [2];
  logic [2:0] ra [2];
  logic ro [2];
  logic ack [2];
  logic [2:0] rd [2];
  logic [7:0] wc [2];
  logic [2:0] la [2];
  logic [2:0] mm [2][8];
  logic [7:0] mc [2];
  exp_t q [$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  slave_regfile #(.READY_DELAY(2), .BUSY_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[0]), .addr_in(ai[0]), .value_in(di[0]),
    .ready_out(ro[0]), .ack_out(ack[0]), .rd_addr(ra[0]), .rd_data(rd[0]),
    .wr_count(wc[0]), .last_addr(la[0])
  );
  slave_regfile #(.READY_DELAY(3), .BUSY_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .valid_in(vi[1]), .addr_in(ai[1]), .value_in(di[1]),
    .ready_out(ro[1]), .ack_out(ack[1]), .rd_addr(ra[1]), .rd_data(rd[1]),
    .wr_count(wc[1]), .last_addr(la[1])
  );
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (rst_n && ack[i]) begin
        if (q.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          e = q.pop_front();
          chk("ack_dut", i, e.i);
          chk("last_addr", la[i], e.a);
          chk("wr_count", wc[i], e.c);
        end
      end
  task automatic push(int i, logic [2:0] a, logic [2:0] v);
    mc[i] = mc[i] + 8'd1;
    mm[i][a] = v;
    q.push_back('{i, a, v, mc[i]});
  endtask
  task automatic wr(int i, logic [2:0] a, logic [2:0] v, bit hold);
    int n = 0;
    vi[i] = 1'b1;
    ai[i] = a;
    di[i] = v;
    push(i, a, v);
    while (!ro[i]) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        chk("ready_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk);
    if (!hold) vi[i] = 1'b0;
  endtask
  task automatic sweep(int i, string tag);
    for (int j = 0; j < 8; j++) begin
      ra[i] = 3'(j);
      #1;
      chk(tag, rd[i], mm[i][j]);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mc[i] = '0;
      for (int j = 0; j < 8; j++) mm[i][j] = '0;
    end
  endtask
  initial begin
    int t1, t2, hi;
    logic [2:0] a, v;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vi[i] = 1'b0;
      ai[i] = '0;
      di[i] = '0;
      ra[i] = '0;
    end
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", ro[i], 0);
      chk("rst_ack", ack[i], 0);
      chk("rst_count", wc[i], 0);
      chk("rst_last", la[i], 0);
      sweep(i, "rst_mem");
    end
    rst_n = 1'b1;
    @(negedge clk);
    vi[0] = 1'b1;
    ai[0] = 3'd5;
    di[0] = 3'd6;
    push(0, 3'd5, 3'd6);
    @(negedge clk);
    chk("lat_c1_ready", ro[0], 0);
    @(negedge clk);
    chk("lat_c2_ready", ro[0], 1);
    chk("lat_c2_ack", ack[0], 0);
    ai[0] = 3'd5;
    @(negedge clk);
    vi[0] = 1'b0;
    chk("lat_c3_ready", ro[0], 0);
    chk("lat_c3_ack", ack[0], 1);
    @(negedge clk);
    chk("lat_c4_ready", ro[0], 0);
    chk("lat_c4_ack", ack[0], 0);
    ra[0] = 3'd5;
    #1;
    chk("lat_mem5", rd[0], 6);
    chk("lat_count", wc[0], 1);
    chk("lat_last", la[0], 5);
    @(negedge clk);
    vi[1] = 1'b1;
    ai[1] = 3'd4;
    di[1] = 3'd3;
    @(negedge clk);
    vi[1] = 1'b0;
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (ro[1]) hi++;
    end
    chk("pulse_ready", hi, 0);
    chk("pulse_count", wc[1], 0);
    sweep(1, "pulse_mem");
    @(negedge clk);
    wr(1, 3'd1, 3'd7, 1);
    t1 = cyc;
    wr(1, 3'd2, 3'd4, 1);
    t2 = cyc;
    chk("b2b_gap1", t2 - t1, 4);
    wr(1, 3'd3, 3'd1, 0);
    chk("b2b_gap2", cyc - t2, 4);
    repeat (2) @(negedge clk);
    chk("b2b_count", wc[1], 3);
    sweep(1, "b2b_mem");
    wr(0, 3'd2, 3'd3, 0);
    repeat (3) @(negedge clk);
    vi[0] = 1'b1;
    ai[0] = 3'd7;
    di[0] = 3'd7;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("arst_ready", ro[0], 0);
    chk("arst_ack", ack[0], 0);
    chk("arst_count", wc[0], 0);
    chk("arst_last", la[0], 0);
    chk("arst_count_b", wc[1], 0);
    ra[0] = 3'd5;
    #1;
    chk("arst_mem5", rd[0], 0);
    vi[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr(0, 3'd0, 3'd2, 0);
    repeat (3) @(negedge clk);
    sweep(0, "post_rst_mem");
    for (int k = 0; k < 256; k++) begin
      a = 3'($urandom_range(0, 7));
      v = 3'($urandom_range(0, 7));
      wr(1, a, v, k % 2 == 0);
    end
    vi[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("wrap_count", wc[1], 0);
    ra[1] = la[1];
    #1;
    chk("wrap_last_val", rd[1], v);
    chk("wrap_last_addr", la[1], a);
    sweep(1, "wrap_mem");
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
